vlc_window_accum: RTL and testbench
===================================

// Module: vlc_window_accum
// PURPOSE
//  Multi-channel windowed bit accumulator for the VLC receive path. Each lane counts
//  ones in a 1-bit sample stream over a fixed window of WINDOW valid samples, then
//  emits the count, an overflow flag and a threshold decision bit, with a one-cycle strobe.
//  Sits between the oversampling front end and the symbol slicer/demapper.
// PARAMETERS
//  CHANNELS  1   number of independent sample lanes
//  WINDOW    10  valid samples per window (>=2)
//  ACC_W     10  accumulator/sum width per lane (>=1); may be < $clog2(WINDOW+1)
// PORTS
//  clk       in   1              clock, rising edge
//  rst       in   1              reset, asynchronous, active-low
//  en        in   1              run enable; 1 = accumulate windows, 0 = abort/idle
//  clr       in   1              synchronous clear, priority over all but rst
//  in_valid  in   1              in_bits qualifier
//  in_bits   in   CHANNELS       one sample bit per lane
//  thresh    in   ACC_W          decision threshold, shared by all lanes
//  sum_out   out  CHANNELS*ACC_W per-lane window count, lane c at [c*ACC_W +: ACC_W]
//  dec_out   out  CHANNELS       per-lane decision, 1 when sum >= thresh (unsigned)
//  ovf_out   out  CHANNELS       per-lane overflow seen during the reported window
//  out_valid out  1              one-cycle strobe: sum/dec/ovf updated this cycle
//  busy      out  1              1 while FSM in RUN
// BEHAVIOUR
//  - Reset (rst=0): all outputs, accumulators, sample counter, sticky ovf = 0; FSM=IDLE.
//  - FSM: IDLE -> RUN when en=1 (no sample taken that edge). RUN -> IDLE when en=0.
//  - In IDLE in_valid ignored. In RUN each edge with in_valid=1: acc[c] += in_bits[c],
//    cnt += 1. Cycles with in_valid=0 change nothing (gaps allowed, any length).
//  - Window end: edge where in_valid=1 and cnt==WINDOW-1. On that edge sum_out gets
//    acc+bit (last sample included), ovf_out gets sticky|this-add overflow, dec_out gets
//    (new sum >= thresh sampled on that edge), out_valid=1 next cycle only; acc, cnt,
//    sticky ovf cleared same edge. Next window starts next cycle, no lost samples.
//    Latency: out_valid 1 cycle after the accepted last sample.
//  - Width: overflow = add carry out of ACC_W bits. Default mode: wrap (mod 2^ACC_W).
//  - en=0 mid-window: partial window discarded (acc/cnt/sticky cleared), no out_valid,
//    FSM->IDLE. If en=0 on the window-end edge, that window still completes and reports.
//  - clr=1: acc, cnt, sticky ovf, out_valid cleared, FSM->IDLE; sum/dec/ovf outputs hold.
//  - sum_out/dec_out/ovf_out hold between strobes.
// CONFIGURATION
//  VLC_ACCU_SAT_EN defined: lane accumulators saturate at 2^ACC_W-1 instead of wrapping;
//   ovf still set on the first attempted increment past max.
//  Undefined: wrap-around arithmetic as above.
// STRUCTURE
//  Package vlc_accu_pkg: FSM state typedef (ST_IDLE, ST_RUN), function cnt_w(WINDOW)
//   = $clog2(WINDOW) for the sample counter width.
//  Sub-module vlc_accu_lane (one per channel, generate loop): acc register, add with
//   carry, sticky ovf, saturation option, output sum/dec/ovf registers. Top holds FSM,
//   shared sample counter, out_valid and busy.
// TESTING
//  1 Defaults, en=1, in_valid=1, in_bits=1 x10 -> one out_valid 1 cycle after 10th, sum=10, ovf=0.
//  2 Pattern 1010.., thresh=5, back-to-back windows of 5 then 4 ones -> dec=1 then dec=0, strobes 10 cycles apart.
//  3 Ten valid ones spread over 25 cycles with random gaps -> exactly one strobe, sum=10.
//  4 ACC_W=3, WINDOW=10, all ones -> sum=2, ovf=1; with VLC_ACCU_SAT_EN -> sum=7, ovf=1.
//  5 en=0 after 6 samples, re-enable, 10 ones -> no strobe for aborted window, then sum=10.
//  6 rst pulsed low mid-window -> outputs 0 immediately (async); clr mid-window -> no strobe, outputs held.

Source files
------------

// File: rtl/vlc_accu_pkg.sv
// vlc_accu_pkg: shared FSM state type and counter-width helper for vlc_window_accum
package vlc_accu_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  function automatic int cnt_w(input int window);
    return $clog2(window);
  endfunction
endpackage

// File: rtl/vlc_window_accum_if.sv
// vlc_window_accum_if: control, sample and result bundle of the windowed bit accumulator
interface vlc_window_accum_if #(
  parameter int CHANNELS = 1,
  parameter int ACC_W    = 10
);
  logic                      en;
  logic                      clr;
  logic                      in_valid;
  logic [CHANNELS-1:0]       in_bits;
  logic [ACC_W-1:0]          thresh;
  logic [CHANNELS*ACC_W-1:0] sum_out;
  logic [CHANNELS-1:0]       dec_out;
  logic [CHANNELS-1:0]       ovf_out;
  logic                      out_valid;
  logic                      busy;
  modport master(output en, clr, in_valid, in_bits, thresh,
                 input sum_out, dec_out, ovf_out, out_valid, busy);
  modport slave(input en, clr, in_valid, in_bits, thresh,
                output sum_out, dec_out, ovf_out, out_valid, busy);
endinterface

// File: rtl/vlc_accu_lane.sv
// vlc_accu_lane: one lane accumulator with sticky overflow and registered window result.
// VLC_ACCU_SAT_EN selects saturating instead of wrapping accumulation.
module vlc_accu_lane #(
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             take_i,
  input  logic             last_i,
  input  logic             bit_i,
  input  logic [ACC_W-1:0] thresh_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             dec_o,
  output logic             ovf_o
);
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, raw, nxt;
  logic             sticky_q, sticky_d, dec_q, dec_d, ovf_q, ovf_d, carry;
  assign {carry, raw} = {1'b0, acc_q} + {{ACC_W{1'b0}}, bit_i};
`ifdef VLC_ACCU_SAT_EN
  assign nxt = carry ? '1 : raw;
`else
  assign nxt = raw;
`endif
  always_comb begin
    acc_d    = (flush_i || last_i) ? '0 : take_i ? nxt : acc_q;
    sticky_d = (flush_i || last_i) ? 1'b0 : take_i ? (sticky_q | carry) : sticky_q;
    sum_d    = last_i ? nxt : sum_q;
    ovf_d    = last_i ? (sticky_q | carry) : ovf_q;
    dec_d    = last_i ? (nxt >= thresh_i) : dec_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      dec_q    <= dec_d;
    end
  end
  assign sum_o = sum_q;
  assign dec_o = dec_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/vlc_window_accum.sv
// vlc_window_accum: multi-lane windowed ones counter with threshold decision and strobe.
// Define VLC_ACCU_SAT_EN for saturating lane accumulators.
module vlc_window_accum
  import vlc_accu_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int WINDOW   = 10,
  parameter int ACC_W    = 10
) (
  input logic               clk,
  input logic               rst,
  vlc_window_accum_if.slave bus
);
  localparam int CW = cnt_w(WINDOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ov_q, run, take, last, flush;
  assign run  = state_q == ST_RUN;
  assign take = run && bus.in_valid && !bus.clr;
  assign last = take && cnt_q == CNT_LAST;
  // dropping en mid-window discards the partial window, except on its closing sample
  assign flush = bus.clr || (run && !bus.en && !last);
  always_comb begin
    state_d = (bus.en && !bus.clr) ? ST_RUN : ST_IDLE;
    cnt_d   = (flush || last) ? '0 : take ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= last;
    end
  end
  assign bus.out_valid = ov_q;
  assign bus.busy      = run;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    vlc_accu_lane #(.ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush),
      .take_i   (take),
      .last_i   (last),
      .bit_i    (bus.in_bits[g]),
      .thresh_i (bus.thresh),
      .sum_o    (bus.sum_out[g*ACC_W +: ACC_W]),
      .dec_o    (bus.dec_out[g]),
      .ovf_o    (bus.ovf_out[g])
    );
  end
endmodule

// File: tb/tb_vlc_window_accum.sv
// tb_vlc_window_accum: directed bench for vlc_window_accum (2-lane ACC_W=10, 1-lane ACC_W=3)
module tb_vlc_window_accum;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  vlc_window_accum_if #(.CHANNELS(2), .ACC_W(10)) bus();
  vlc_window_accum_if #(.CHANNELS(1), .ACC_W(3))  b3();
  vlc_window_accum #(.CHANNELS(2), .WINDOW(10), .ACC_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  vlc_window_accum #(.CHANNELS(1), .WINDOW(10), .ACC_W(3))  dut3 (.clk(clk), .rst(rst), .bus(b3));
  int nvec = 0, nerr = 0, ncyc = 0, nstb = 0, stb_cyc = 0, n0 = 0, c1 = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic cyc(input logic v, input logic [1:0] b);
    bus.in_valid = v;
    bus.in_bits  = b;
    @(posedge clk);
    #1;
    ncyc++;
    if (bus.out_valid) begin
      nstb++;
      stb_cyc = ncyc;
    end
  endtask
  function automatic logic [9:0] lane_sum(input int c);
    return bus.sum_out[c*10 +: 10];
  endfunction
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.en = 0; bus.clr = 0; bus.in_valid = 0; bus.in_bits = 0; bus.thresh = 10'd5;
    b3.en = 0; b3.clr = 0; b3.in_valid = 0; b3.in_bits = 0; b3.thresh = 3'd3;
    #12;
    check("rst_sum", bus.sum_out, 0);
    check("rst_dec", bus.dec_out, 0);
    check("rst_ovf", bus.ovf_out, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk) rst = 1;
    // window of ten ones on lane 0, zeros on lane 1
    bus.en = 1;
    cyc(0, 2'b00);
    check("t1_busy", bus.busy, 1);
    for (int i = 0; i < 9; i++) cyc(1, 2'b01);
    check("t1_early", nstb, 0);
    cyc(1, 2'b01);
    check("t1_strobe", bus.out_valid, 1);
    check("t1_nstb", nstb, 1);
    check("t1_sum0", lane_sum(0), 10);
    check("t1_sum1", lane_sum(1), 0);
    check("t1_dec", bus.dec_out, 2'b01);
    check("t1_ovf", bus.ovf_out, 0);
    cyc(0, 2'b00);
    check("t1_pulse", bus.out_valid, 0);
    check("t1_hold", lane_sum(0), 10);
    // back-to-back windows: lane0 5 then 4 ones, lane1 complement 5 then 6
    n0 = nstb;
    for (int i = 0; i < 10; i++) cyc(1, (i % 2 == 0) ? 2'b01 : 2'b10);
    check("t2_sum0a", lane_sum(0), 5);
    check("t2_sum1a", lane_sum(1), 5);
    check("t2_deca", bus.dec_out, 2'b11);
    c1 = stb_cyc;
    for (int i = 0; i < 10; i++) cyc(1, (i % 2 == 0 && i < 8) ? 2'b01 : 2'b10);
    check("t2_sum0b", lane_sum(0), 4);
    check("t2_sum1b", lane_sum(1), 6);
    check("t2_decb", bus.dec_out, 2'b10);
    check("t2_spacing", stb_cyc - c1, 10);
    check("t2_nstb", nstb - n0, 2);
    // ten valid samples spread over 25 cycles
    n0 = nstb;
    for (int i = 0; i < 25; i++) cyc(i % 5 == 0 || i % 5 == 2, 2'b11);
    cyc(0, 2'b00);
    cyc(0, 2'b00);
    check("t3_nstb", nstb - n0, 1);
    check("t3_sum0", lane_sum(0), 10);
    check("t3_sum1", lane_sum(1), 10);
    // abort after 6 samples, then a fresh window
    n0 = nstb;
    for (int i = 0; i < 6; i++) cyc(1, 2'b01);
    bus.en = 0;
    cyc(1, 2'b01);
    check("t5_idle", bus.busy, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b01);
    bus.en = 1;
    cyc(0, 2'b00);
    for (int i = 0; i < 10; i++) cyc(1, 2'b10);
    check("t5_nstb", nstb - n0, 1);
    check("t5_sum0", lane_sum(0), 0);
    check("t5_sum1", lane_sum(1), 10);
    // en dropped on the closing sample still reports
    for (int i = 0; i < 9; i++) cyc(1, 2'b11);
    bus.en = 0;
    cyc(1, 2'b11);
    check("t5_end_strobe", bus.out_valid, 1);
    check("t5_end_sum0", lane_sum(0), 10);
    check("t5_end_busy", bus.busy, 0);
    cyc(0, 2'b00);
    // narrow accumulator overflow
    b3.en = 1;
    @(posedge clk); #1;
    b3.in_valid = 1;
    b3.in_bits = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    b3.in_valid = 0;
    b3.en = 0;
    check("t4_strobe", b3.out_valid, 1);
    check("t4_ovf", b3.ovf_out, 1);
`ifdef VLC_ACCU_SAT_EN
    check("t4_sum", b3.sum_out, 7);
    check("t4_dec", b3.dec_out, 1);
`else
    check("t4_sum", b3.sum_out, 2);
    check("t4_dec", b3.dec_out, 0);
`endif
    // clr mid-window: no strobe, outputs held, counter restarted
    bus.en = 1;
    cyc(0, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1, 2'b11);
    bus.clr = 1;
    cyc(1, 2'b11);
    check("t6_clr_valid", bus.out_valid, 0);
    check("t6_clr_busy", bus.busy, 0);
    check("t6_clr_hold", lane_sum(0), 10);
    bus.clr = 0;
    cyc(0, 2'b00);
    n0 = nstb;
    for (int i = 0; i < 10; i++) cyc(1, 2'b10);
    check("t6_nstb", nstb - n0, 1);
    check("t6_sum0", lane_sum(0), 0);
    check("t6_sum1", lane_sum(1), 10);
    check("t6_dec", bus.dec_out, 2'b10);
    // asynchronous reset mid-window
    for (int i = 0; i < 3; i++) cyc(1, 2'b11);
    #3;
    rst = 0;
    #1;
    check("t6_arst_sum", bus.sum_out, 0);
    check("t6_arst_dec", bus.dec_out, 0);
    check("t6_arst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1;
    bus.en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
